mouse_cursor: RTL and testbench
===============================

Name: mouse_cursor

Overview:
- Sits directly downstream of the PS/2 mouse packet decoder and consumes its per-packet outputs: 9-bit two's-complement X/Y deltas, 3-bit button state and the 1-cycle packet-done tick.
- Integrates the deltas into an absolute, screen-clamped cursor position for the display and the CPU.
- Converts button-state changes into press/release events, buffered in a small FIFO that the CPU drains through a valid/read handshake.

Parameters:
- POS_W, 10, width of the cur_x/cur_y position outputs.
- X_MAX, 639, largest legal X coordinate; must be less than 2^POS_W.
- Y_MAX, 479, largest legal Y coordinate; must be less than 2^POS_W.
- X_INIT, 320, X position after reset or recenter.
- Y_INIT, 240, Y position after reset or recenter.
- FIFO_DEPTH, 4, number of entries in the event FIFO; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- xm  in  9  X delta in two's complement; positive means right. Valid in the cycle m_done_tick is high.
- ym  in  9  Y delta in two's complement; positive means up (PS/2 convention). Valid with m_done_tick.
- btnm  in  3  button state {middle, right, left}; 1 means pressed. Valid with m_done_tick.
- m_done_tick  in  1  1-cycle pulse: a new packet is valid.
- recenter  in  1  synchronous pulse: return the cursor to (X_INIT, Y_INIT).
- cur_x  out  POS_W  absolute X position, 0..X_MAX.
- cur_y  out  POS_W  absolute Y position, 0..Y_MAX; 0 is the top of the screen.
- btn  out  3  registered button state.
- move_tick  out  1  1-cycle pulse: cur_x/cur_y/btn were just updated from a packet.
- evt_valid  out  1  event FIFO is not empty.
- evt_data  out  6  head event {released[2:0], pressed[2:0]}.
- evt_rd  in  1  pop the head event; ignored when evt_valid is 0.
- evt_ovf  out  1  sticky flag: an event was dropped because the FIFO was full.
- evt_ovf_clr  in  1  synchronous clear of evt_ovf.

Behaviour:
- Reset values:
  - cur_x = X_INIT, cur_y = Y_INIT.
  - btn = 0.
  - move_tick = 0.
  - FIFO empty, so evt_valid = 0 and evt_data = 0.
  - evt_ovf = 0.
- Latency: a packet presented with m_done_tick in cycle N is captured at the clock edge ending cycle N. Updated cur_x/cur_y/btn and move_tick=1 appear in cycle N+1. Any resulting event is visible at the FIFO head (evt_valid) from cycle N+1 if the FIFO was empty.
- X arithmetic:
  - Sign-extend xm to POS_W+2 bits.
  - sum_x = cur_x + sext(xm), signed.
  - If sum_x < 0, cur_x = 0; if sum_x > X_MAX, cur_x = X_MAX; otherwise cur_x = sum_x.
- Y arithmetic (screen Y is inverted relative to PS/2):
  - sum_y = cur_y - sext(ym).
  - Clamp to 0..Y_MAX the same way as X.
- Full-range deltas: -256 and +255 must clamp correctly from any position. No internal wrap is allowed.
- Button events, evaluated only when m_done_tick is high:
  - pressed = btnm & ~btn.
  - released = ~btnm & btn.
  - btn <= btnm.
  - If pressed or released is non-zero, push {released, pressed} as one entry. No push when neither changed.
- Event FIFO:
  - Circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH) for full/empty detection.
  - evt_data is the head entry combinationally from storage, and is 0 when empty.
  - Pop occurs on evt_rd && evt_valid.
  - Push to a full FIFO with a simultaneous pop: both happen, nothing is dropped, evt_ovf is unchanged.
  - Push to a full FIFO without a pop: the new event is dropped and evt_ovf <= 1. The FIFO contents are unchanged.
  - Push and pop on an empty FIFO: the push happens, the pop is ignored.
  - evt_ovf_clr and an overflow in the same cycle: evt_ovf stays 1 (set wins).
- recenter:
  - Sets cur_x = X_INIT, cur_y = Y_INIT on the next edge.
  - If it coincides with m_done_tick, recenter wins for position: the deltas are discarded.
  - Button tracking, event push and move_tick still occur for that packet.
  - recenter alone does not raise move_tick and does not touch the FIFO.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to the reset values and pending events are lost.

Decomposition:
- mouse_pkg holds:
  - EVT_W = 6.
  - The event struct type {released[2:0], pressed[2:0]}.
  - The button index constants BTN_L = 0, BTN_R = 1, BTN_M = 2.
- Sub-module mouse_evt_fifo(FIFO_DEPTH): push/pop/full/empty/overflow logic.
- The top level contains the accumulator/clamp logic, the button edge logic and the FIFO instance.

Test Plan:
- Reset, then one packet xm=+10, ym=+5, btnm=0 -> cycle N+1: cur_x=330, cur_y=235, move_tick=1 for exactly 1 cycle, evt_valid=0.
- From (320,240), xm=9'h100 (-256) twice -> cur_x=64, then cur_x=0. From cur_x=630, xm=+255 -> cur_x=639. From cur_y=470, ym=-256 -> cur_y=479.
- btnm 000 -> 001 -> 011 -> 000 over three packets -> evt_data sequence 6'h01, 6'h02, 6'h18. evt_rd pops in order and evt_valid drops after the third pop.
- Five button-change packets with no reads (DEPTH=4) -> 4 entries held, the fifth dropped, evt_ovf=1. evt_ovf_clr -> evt_ovf=0. A push coinciding with evt_rd while full -> no overflow.
- recenter in the same cycle as a packet xm=+50, btnm=100 -> cur=(320,240), btn=100, event 6'h04 pushed, move_tick=1.
- Assert reset mid-stream with 2 events queued and cur=(100,100) -> cur=(320,240), btn=0, evt_valid=0, evt_ovf=0.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse cursor block.
// The event record packs the released buttons above the pressed buttons.
package mouse_pkg;

   localparam int EVT_W = 6;

   localparam int BTN_L = 0;
   localparam int BTN_R = 1;
   localparam int BTN_M = 2;

   typedef struct packed {
      logic [2:0] released;
      logic [2:0] pressed;
   } evt_t;

   // Edge-detect one packet's button state against the previously held state.
   function automatic evt_t make_evt(input logic [2:0] prev, input logic [2:0] now);
      evt_t e;
      e.pressed  = now & ~prev;
      e.released = ~now & prev;
      return e;
   endfunction

endpackage

// File: rtl/mouse_evt_fifo.sv
// Button-event FIFO. A push into a full FIFO is dropped and raises a sticky
// overflow flag, unless a pop in the same cycle makes room for it.
module mouse_evt_fifo
   import mouse_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  evt_t push_data,
   input  logic pop,
   input  logic ovf_clr,
   output evt_t head,
   output logic valid,
   output logic ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   logic        ovf_r;
   evt_t        mem_r [FIFO_DEPTH];

   logic empty_s;
   logic full_s;
   logic pop_s;
   logic wr_s;
   logic drop_s;

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_s   = pop && !empty_s;
   assign wr_s    = push && (!full_s || pop_s);
   assign drop_s  = push && full_s && !pop_s;

   // Pointers and the sticky overflow flag; a drop wins over a clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         ovf_r    <= 1'b0;
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Entry storage; stale contents are masked by the empty check below.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

   assign head  = empty_s ? evt_t'({EVT_W{1'b0}}) : mem_r[rd_ptr_r[AW-1:0]];
   assign valid = !empty_s;
   assign ovf   = ovf_r;

endmodule

// File: rtl/mouse_cursor.sv
// Integrates PS/2 mouse deltas into a screen-clamped cursor position and turns
// button changes into press/release events queued for the CPU.
module mouse_cursor
   import mouse_pkg::*;
#(
   parameter int POS_W      = 10,
   parameter int X_MAX      = 639,
   parameter int Y_MAX      = 479,
   parameter int X_INIT     = 320,
   parameter int Y_INIT     = 240,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [8:0]       xm,
   input  logic [8:0]       ym,
   input  logic [2:0]       btnm,
   input  logic             m_done_tick,
   input  logic             recenter,
   output logic [POS_W-1:0] cur_x,
   output logic [POS_W-1:0] cur_y,
   output logic [2:0]       btn,
   output logic             move_tick,
   output logic             evt_valid,
   output logic [5:0]       evt_data,
   input  logic             evt_rd,
   output logic             evt_ovf,
   input  logic             evt_ovf_clr
);

   // Two guard bits keep full-range deltas from wrapping before the clamp.
   localparam int SW = POS_W + 2;
   localparam logic signed [SW-1:0] ZERO_S  = {SW{1'b0}};
   localparam logic signed [SW-1:0] X_MAX_S = SW'(X_MAX);
   localparam logic signed [SW-1:0] Y_MAX_S = SW'(Y_MAX);
   localparam logic [POS_W-1:0] X_MAX_V  = POS_W'(X_MAX);
   localparam logic [POS_W-1:0] Y_MAX_V  = POS_W'(Y_MAX);
   localparam logic [POS_W-1:0] X_INIT_V = POS_W'(X_INIT);
   localparam logic [POS_W-1:0] Y_INIT_V = POS_W'(Y_INIT);

   logic [POS_W-1:0] cur_x_r;
   logic [POS_W-1:0] cur_y_r;
   logic [2:0]       btn_r;
   logic             move_tick_r;

   logic signed [SW-1:0] dx_s;
   logic signed [SW-1:0] dy_s;
   logic signed [SW-1:0] sum_x_s;
   logic signed [SW-1:0] sum_y_s;
   logic [POS_W-1:0]     nx_s;
   logic [POS_W-1:0]     ny_s;
   evt_t                 evt_s;
   evt_t                 evt_head_s;
   logic                 push_s;

   assign dx_s    = {{(SW-9){xm[8]}}, xm};
   assign dy_s    = {{(SW-9){ym[8]}}, ym};
   assign sum_x_s = $signed({2'b00, cur_x_r}) + dx_s;
   // PS/2 reports up as positive while screen row 0 is the top.
   assign sum_y_s = $signed({2'b00, cur_y_r}) - dy_s;

   // Clamp both candidate positions to the visible screen.
   always_comb begin
      nx_s = {POS_W{1'b0}};
      ny_s = {POS_W{1'b0}};
      if (sum_x_s < ZERO_S) begin
         nx_s = {POS_W{1'b0}};
      end else if (sum_x_s > X_MAX_S) begin
         nx_s = X_MAX_V;
      end else begin
         nx_s = sum_x_s[POS_W-1:0];
      end
      if (sum_y_s < ZERO_S) begin
         ny_s = {POS_W{1'b0}};
      end else if (sum_y_s > Y_MAX_S) begin
         ny_s = Y_MAX_V;
      end else begin
         ny_s = sum_y_s[POS_W-1:0];
      end
   end

   assign evt_s  = make_evt(btn_r, btnm);
   assign push_s = m_done_tick && (|evt_s);

   // Position, button and move-tick registers; recenter overrides packet motion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_x_r     <= X_INIT_V;
         cur_y_r     <= Y_INIT_V;
         btn_r       <= 3'b000;
         move_tick_r <= 1'b0;
      end else begin
         move_tick_r <= m_done_tick;
         if (recenter) begin
            cur_x_r <= X_INIT_V;
            cur_y_r <= Y_INIT_V;
         end else if (m_done_tick) begin
            cur_x_r <= nx_s;
            cur_y_r <= ny_s;
         end
         if (m_done_tick) begin
            btn_r <= btnm;
         end
      end
   end

   mouse_evt_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_evt_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (evt_s),
      .pop       (evt_rd),
      .ovf_clr   (evt_ovf_clr),
      .head      (evt_head_s),
      .valid     (evt_valid),
      .ovf       (evt_ovf)
   );

   assign cur_x     = cur_x_r;
   assign cur_y     = cur_y_r;
   assign btn       = btn_r;
   assign move_tick = move_tick_r;
   assign evt_data  = evt_head_s;

endmodule

// File: tb/tb_mouse_cursor.sv
// Directed, table-driven bench for mouse_cursor with hand-computed expectations
// and hand-written sequences for FIFO overflow, recenter and mid-stream reset.
module tb_mouse_cursor;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] xm;
   logic [8:0] ym;
   logic [2:0] btnm;
   logic       m_done_tick;
   logic       recenter;
   logic [9:0] cur_x;
   logic [9:0] cur_y;
   logic [2:0] btn;
   logic       move_tick;
   logic       evt_valid;
   logic [5:0] evt_data;
   logic       evt_rd;
   logic       evt_ovf;
   logic       evt_ovf_clr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [8:0] xm;
      logic [8:0] ym;
      logic [2:0] btnm;
      logic       rc;
      int         ex;
      int         ey;
      logic [2:0] eb;
      logic       ev;
      logic [5:0] ed;
   } vec_t;

   vec_t tbl [14];

   mouse_cursor dut (
      .clk         (clk),
      .reset       (reset),
      .xm          (xm),
      .ym          (ym),
      .btnm        (btnm),
      .m_done_tick (m_done_tick),
      .recenter    (recenter),
      .cur_x       (cur_x),
      .cur_y       (cur_y),
      .btn         (btn),
      .move_tick   (move_tick),
      .evt_valid   (evt_valid),
      .evt_data    (evt_data),
      .evt_rd      (evt_rd),
      .evt_ovf     (evt_ovf),
      .evt_ovf_clr (evt_ovf_clr)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b,
                               input logic rc, input int ex, input int ey, input logic [2:0] eb,
                               input logic ev, input logic [5:0] ed);
      vec_t v;
      v.xm = x; v.ym = y; v.btnm = b; v.rc = rc;
      v.ex = ex; v.ey = ey; v.eb = eb; v.ev = ev; v.ed = ed;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs at a falling edge, then idle them one cycle later.
   task automatic drive(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b,
                        input logic done, input logic rc, input logic rd, input logic clr);
      @(negedge clk);
      xm = x; ym = y; btnm = b; m_done_tick = done; recenter = rc;
      evt_rd = rd; evt_ovf_clr = clr;
      @(negedge clk);
      xm = 9'd0; ym = 9'd0; btnm = 3'b000; m_done_tick = 1'b0; recenter = 1'b0;
      evt_rd = 1'b0; evt_ovf_clr = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      drive(v.xm, v.ym, v.btnm, 1'b1, v.rc, 1'b0, 1'b0);
      chk({tag, " move_tick"}, move_tick, 1);
      chk({tag, " cur_x"}, cur_x, v.ex);
      chk({tag, " cur_y"}, cur_y, v.ey);
      chk({tag, " btn"}, btn, v.eb);
      chk({tag, " evt_valid"}, evt_valid, v.ev);
      chk({tag, " evt_data"}, evt_data, v.ed);
      @(negedge clk);
      chk({tag, " move_tick_low"}, move_tick, 0);
   endtask

   initial begin
      logic [5:0] exp_q [$];

      tbl[0]  = mk(9'h100, 9'h000, 3'b000, 1'b0,  64, 240, 3'b000, 1'b0, 6'h00);
      tbl[1]  = mk(9'h100, 9'h000, 3'b000, 1'b0,   0, 240, 3'b000, 1'b0, 6'h00);
      tbl[2]  = mk(9'h0FF, 9'h000, 3'b000, 1'b0, 255, 240, 3'b000, 1'b0, 6'h00);
      tbl[3]  = mk(9'h0FF, 9'h000, 3'b000, 1'b0, 510, 240, 3'b000, 1'b0, 6'h00);
      tbl[4]  = mk(9'h078, 9'h000, 3'b000, 1'b0, 630, 240, 3'b000, 1'b0, 6'h00);
      tbl[5]  = mk(9'h0FF, 9'h000, 3'b000, 1'b0, 639, 240, 3'b000, 1'b0, 6'h00);
      tbl[6]  = mk(9'h000, 9'h0FF, 3'b000, 1'b0, 639,   0, 3'b000, 1'b0, 6'h00);
      tbl[7]  = mk(9'h000, 9'h100, 3'b000, 1'b0, 639, 256, 3'b000, 1'b0, 6'h00);
      tbl[8]  = mk(9'h000, 9'h12A, 3'b000, 1'b0, 639, 470, 3'b000, 1'b0, 6'h00);
      tbl[9]  = mk(9'h000, 9'h100, 3'b000, 1'b0, 639, 479, 3'b000, 1'b0, 6'h00);
      tbl[10] = mk(9'h1FF, 9'h001, 3'b001, 1'b0, 638, 478, 3'b001, 1'b1, 6'h01);
      tbl[11] = mk(9'h000, 9'h000, 3'b011, 1'b0, 638, 478, 3'b011, 1'b1, 6'h01);
      tbl[12] = mk(9'h000, 9'h000, 3'b000, 1'b0, 638, 478, 3'b000, 1'b1, 6'h01);
      tbl[13] = mk(9'h000, 9'h000, 3'b000, 1'b0, 638, 478, 3'b000, 1'b1, 6'h01);

      reset = 1'b1; xm = 9'd0; ym = 9'd0; btnm = 3'b000; m_done_tick = 1'b0;
      recenter = 1'b0; evt_rd = 1'b0; evt_ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst cur_x", cur_x, 320);
      chk("rst cur_y", cur_y, 240);
      chk("rst btn", btn, 0);
      chk("rst move_tick", move_tick, 0);
      chk("rst evt_valid", evt_valid, 0);
      chk("rst evt_data", evt_data, 0);
      chk("rst evt_ovf", evt_ovf, 0);
      reset = 1'b0;

      apply_vec(mk(9'h00A, 9'h005, 3'b000, 1'b0, 330, 235, 3'b000, 1'b0, 6'h00), "first_pkt");

      // Recenter alone: position returns, no move tick, FIFO untouched.
      drive(9'd0, 9'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("recenter cur_x", cur_x, 320);
      chk("recenter cur_y", cur_y, 240);
      chk("recenter move_tick", move_tick, 0);
      chk("recenter evt_valid", evt_valid, 0);

      for (int i = 0; i < 14; i++) begin
         apply_vec(tbl[i], $sformatf("vec%0d", i));
      end

      exp_q = '{6'h01, 6'h02, 6'h18};
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("pop%0d valid", k), evt_valid, 1);
         chk($sformatf("pop%0d data", k), evt_data, exp_q[k]);
         drive(9'd0, 9'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("drained valid", evt_valid, 0);
      chk("drained data", evt_data, 0);

      // Five changes into a depth-4 FIFO; the fifth also carries a clear, which loses.
      for (int i = 0; i < 5; i++) begin
         drive(9'd0, 9'd0, (i % 2 == 0) ? 3'b001 : 3'b000, 1'b1, 1'b0, 1'b0, (i == 4));
         if (i == 3) chk("full no ovf yet", evt_ovf, 0);
      end
      chk("ovf set", evt_ovf, 1);
      chk("ovf head", evt_data, 6'h01);
      drive(9'd0, 9'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovf cleared", evt_ovf, 0);

      // Push while full with a simultaneous pop: nothing dropped.
      drive(9'd0, 9'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("push_pop_full ovf", evt_ovf, 0);
      exp_q = '{6'h08, 6'h01, 6'h08, 6'h08};
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovf_pop%0d data", k), evt_data, exp_q[k]);
         drive(9'd0, 9'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("ovf drained valid", evt_valid, 0);

      apply_vec(mk(9'h032, 9'h000, 3'b100, 1'b1, 320, 240, 3'b100, 1'b1, 6'h04), "recenter_pkt");
      apply_vec(mk(9'h124, 9'h08C, 3'b000, 1'b0, 100, 100, 3'b000, 1'b1, 6'h04), "pre_reset");

      // Asynchronous reset in the middle of a cycle with two events queued.
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst cur_x", cur_x, 320);
      chk("mid_rst cur_y", cur_y, 240);
      chk("mid_rst btn", btn, 0);
      chk("mid_rst evt_valid", evt_valid, 0);
      chk("mid_rst evt_data", evt_data, 0);
      chk("mid_rst evt_ovf", evt_ovf, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst evt_valid", evt_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
